sdio_wbarbiter: RTL and testbench

Two-master Wishbone (pipelined) arbiter that shares the single register port of `sdio_top` between two bus requesters, e.g. a CPU and a DMA/command sequencer. It grants the slave to one master for the whole of its `cyc` cycle, using round-robin on contention. It routes stall, ack and read data back to the owner only. An outstanding-request counter bounds in-flight transactions, so that an ack is never misrouted after a grant change.

---
 rtl/sdio_wbarbiter.sv | 118 +++++++++++
 tb/tb_sdio_wbarbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_wbarbiter.sv
// Two-master pipelined Wishbone arbiter in front of the sdio_top register port.
// Ownership lasts a full cyc; contention is resolved round-robin via the last-served bit.
module sdio_wbarbiter #(
    parameter int AW      = 3,
    parameter int DW      = 32,
    parameter int LGOUTST = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic [DW-1:0]   o_b_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [DW-1:0]   i_wb_data
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t             state, state_nxt;
    logic               last, last_nxt;   // 1: B was served most recently
    logic [LGOUTST-1:0] outst;
    logic               own_a, own_b, own_cyc, own_stb;
    logic               a_req, b_req, limit, accept, ack_ok;

    assign a_req   = i_a_cyc && i_a_stb;
    assign b_req   = i_b_cyc && i_b_stb;
    assign own_a   = (state == OWN_A);
    assign own_b   = (state == OWN_B);
    assign own_cyc = (own_a && i_a_cyc) || (own_b && i_b_cyc);
    assign own_stb = own_cyc && ((own_a && i_a_stb) || (own_b && i_b_stb));
    assign limit   = &outst;
    assign accept  = o_wb_stb && !i_wb_stall;
    // Acks with nothing in flight belong to an abandoned cycle and are swallowed
    assign ack_ok  = i_wb_ack && own_cyc && (outst != '0);

    // Arbitration also runs in the cycle the owner drops cyc, allowing direct handoff
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        if (!own_cyc) begin
            state_nxt = IDLE;
            if (a_req && (!b_req || last)) begin
                state_nxt = OWN_A;
                last_nxt  = 1'b0;
            end else if (b_req) begin
                state_nxt = OWN_B;
                last_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
            outst <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (!own_cyc)
                outst <= '0;
            else if (accept && !ack_ok)
                outst <= outst + 1'b1;
            else if (!accept && ack_ok)
                outst <= outst - 1'b1;
        end
    end

    always_comb begin
        o_wb_cyc  = own_cyc;
        o_wb_stb  = own_stb && !limit;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        if (own_a) begin
            o_wb_we   = i_a_we;
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
        end else if (own_b) begin
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
        end
    end

    assign o_a_stall = !own_a || i_wb_stall || limit;
    assign o_b_stall = !own_b || i_wb_stall || limit;
    assign o_a_ack   = ack_ok && own_a;
    assign o_b_ack   = ack_ok && own_b;
    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

endmodule

// File: tb/tb_sdio_wbarbiter.sv
// Scoreboard bench for sdio_wbarbiter: slave-side requests and per-master acks
// are checked against queues filled from the stimulus.
module tb_sdio_wbarbiter;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
    logic [1:0][2:0]  m_addr = '0;
    logic [1:0][3:0]  m_sel = '0;
    logic [1:0][31:0] m_data = '0;
    wire  [1:0]       s_stall, s_ack;
    wire  [1:0][31:0] s_data;

    wire         wb_cyc, wb_stb, wb_we;
    wire  [2:0]  wb_addr;
    wire  [31:0] wb_wdata;
    wire  [3:0]  wb_sel;
    logic        slv_stall = 1'b0, man_ack = 1'b0, auto_ack = 1'b0, acc_d = 1'b0;
    logic [31:0] man_data = '0;
    logic [2:0]  addr_d = '0;
    wire         wb_ack   = auto_ack ? acc_d : man_ack;
    wire  [31:0] wb_rdata = auto_ack ? (32'hF00D_0000 | 32'(addr_d)) : man_data;

    sdio_wbarbiter #(.AW(3), .DW(32), .LGOUTST(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_a_cyc(m_cyc[0]), .i_a_stb(m_stb[0]), .i_a_we(m_we[0]), .i_a_addr(m_addr[0]),
        .i_a_data(m_data[0]), .i_a_sel(m_sel[0]),
        .o_a_stall(s_stall[0]), .o_a_ack(s_ack[0]), .o_a_data(s_data[0]),
        .i_b_cyc(m_cyc[1]), .i_b_stb(m_stb[1]), .i_b_we(m_we[1]), .i_b_addr(m_addr[1]),
        .i_b_data(m_data[1]), .i_b_sel(m_sel[1]),
        .o_b_stall(s_stall[1]), .o_b_ack(s_ack[1]), .o_b_data(s_data[1]),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
        .i_wb_stall(slv_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
    );

    // Slave model for the fairness run: ack every accepted request one cycle later
    always @(posedge clk) begin
        acc_d  <= wb_stb && !slv_stall;
        addr_d <= wb_addr;
    end

    int n_cmp = 0, n_bad = 0, n_acc = 0;
    req_t        req_q[$];
    logic [31:0] ack_qa[$], ack_qb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int x);
        req_q.push_back({m_we[x], m_addr[x], m_sel[x], m_data[x]});
    endtask

    task automatic push_ack(input int x, input logic [31:0] d);
        if (x == 0) ack_qa.push_back(d);
        else        ack_qb.push_back(d);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT produces bus/ack activity
    always begin
        @(negedge clk);
        #2;
        if (wb_stb && !slv_stall) begin
            n_acc++;
            chk("req_expected", 64'(req_q.size() != 0), 1);
            if (req_q.size() != 0) chk("req", {wb_we, wb_addr, wb_sel, wb_wdata}, req_q.pop_front());
        end
        if (s_ack[0]) begin
            chk("a_ack_expected", 64'(ack_qa.size() != 0), 1);
            if (ack_qa.size() != 0) chk("a_ack_data", s_data[0], ack_qa.pop_front());
        end
        if (s_ack[1]) begin
            chk("b_ack_expected", 64'(ack_qb.size() != 0), 1);
            if (ack_qb.size() != 0) chk("b_ack_data", s_data[1], ack_qb.pop_front());
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; m_cyc = '0; m_stb = '0; man_ack = 1'b0;
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_bus", {wb_we, wb_addr, wb_sel, wb_wdata}, 0);
        chk("rst_stall", s_stall, 2'b11);
        chk("rst_ack", s_ack, 2'b00);
    endtask

    // Finish the owner's single transaction: ack it, then drop cyc
    task automatic ack1(input int x);
        nxt();
        m_stb[x] = 1'b0; man_ack = 1'b1; man_data = 32'h5A5A_0000 + 32'(x);
        push_ack(x, man_data);
        @(negedge clk);
        chk("ack1_routed", s_ack[x], 1);
        chk("ack1_other", s_ack[1-x], 0);
        nxt();
        man_ack = 1'b0; m_cyc[x] = 1'b0;
    endtask

    int acc[2], ackc[2], wt[2];
    int glog[$];
    bit done;
    int acc0;

    initial begin
        m_sel[0] = 4'hF; m_sel[1] = 4'h3;
        nxt();
        do_reset();

        // Simultaneous first request, then handoff and round-robin
        nxt();
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11;
        m_addr[0] = 3'd1; m_addr[1] = 3'd2;
        m_data[0] = 32'hAAAA_0001; m_data[1] = 32'hBBBB_0002;
        push_req(0);
        @(negedge clk);
        chk("t2_wait_a", s_stall[0], 1);
        chk("t2_wait_b", s_stall[1], 1);
        nxt();
        @(negedge clk);
        chk("t2_own_a", s_stall[0], 0);
        chk("t2_hold_b", s_stall[1], 1);
        ack1(0);
        push_req(1);
        @(negedge clk);
        chk("t2_gap_cyc", wb_cyc, 0);
        chk("t2_gap_b", s_stall[1], 1);
        nxt();
        @(negedge clk);
        chk("t2_own_b", s_stall[1], 0);
        chk("t2_own_b_stb", wb_stb, 1);
        chk("t2_lock_a", s_stall[0], 1);
        ack1(1);
        @(negedge clk);
        nxt();
        m_cyc = 2'b11; m_stb = 2'b11; m_addr[0] = 3'd5; m_addr[1] = 3'd6;
        push_req(0);
        @(negedge clk);
        chk("t2_rr_wait", s_stall, 2'b11);
        nxt();
        @(negedge clk);
        chk("t2_rr_a", s_stall[0], 0);
        chk("t2_rr_b", s_stall[1], 1);
        ack1(0);
        push_req(1);
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("t2_handoff_b", s_stall[1], 0);
        ack1(1);
        @(negedge clk);

        // Single master, single read
        do_reset();
        nxt();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 3'd3; m_data[0] = '0;
        push_req(0);
        @(negedge clk);
        chk("t1_grant_stall", s_stall[0], 1);
        chk("t1_grant_stb", wb_stb, 0);
        nxt();
        @(negedge clk);
        chk("t1_stb", wb_stb, 1);
        chk("t1_addr", wb_addr, 3);
        chk("t1_stall", s_stall[0], 0);
        nxt();
        m_stb[0] = 1'b0; man_ack = 1'b1; man_data = 32'h1234_5678;
        push_ack(0, 32'h1234_5678);
        @(negedge clk);
        chk("t1_ack", s_ack[0], 1);
        chk("t1_data", s_data[0], 32'h1234_5678);
        chk("t1_b_ack", s_ack[1], 0);
        chk("t1_stb_once", wb_stb, 0);
        nxt();
        man_ack = 1'b0; m_cyc[0] = 1'b0;
        @(negedge clk);
        chk("t1_cyc_drop", wb_cyc, 0);

        // Outstanding limit (3 with LGOUTST=2)
        do_reset();
        nxt();
        acc0 = n_acc;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 3'd0; m_data[0] = 32'hC000_0000;
        push_req(0);
        @(negedge clk);
        chk("lim_grant", s_stall[0], 1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            if (i > 0) begin
                m_addr[0] = 3'(i); m_data[0] = 32'hC000_0000 + 32'(i);
                push_req(0);
            end
            @(negedge clk);
            chk("lim_accept", s_stall[0], 0);
        end
        nxt();
        m_addr[0] = 3'd3; m_data[0] = 32'hC000_0003;
        push_req(0);
        @(negedge clk);
        chk("lim_stall", s_stall[0], 1);
        chk("lim_stb", wb_stb, 0);
        chk("lim_count3", n_acc - acc0, 3);
        nxt();
        @(negedge clk);
        chk("lim_stall2", s_stall[0], 1);
        nxt();
        man_ack = 1'b1; man_data = '0; push_ack(0, '0);
        @(negedge clk);
        chk("lim_ack_cycle", s_stall[0], 1);
        nxt();
        man_ack = 1'b0;
        @(negedge clk);
        chk("lim_release1", s_stall[0], 0);
        nxt();
        m_addr[0] = 3'd4; m_data[0] = 32'hC000_0004;
        push_req(0);
        @(negedge clk);
        chk("lim_restall", s_stall[0], 1);
        chk("lim_count4", n_acc - acc0, 4);
        nxt();
        man_ack = 1'b1; push_ack(0, '0);
        @(negedge clk);
        nxt();
        man_ack = 1'b0;
        @(negedge clk);
        chk("lim_release2", s_stall[0], 0);
        nxt();
        m_stb[0] = 1'b0; man_ack = 1'b1; push_ack(0, '0);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            nxt();
            push_ack(0, '0);
            @(negedge clk);
        end
        nxt();
        man_ack = 1'b0; m_cyc[0] = 1'b0;
        @(negedge clk);
        chk("lim_total", n_acc - acc0, 5);
        chk("lim_cyc_drop", wb_cyc, 0);

        // Abort mid-burst: stale acks arrive while B owns
        do_reset();
        nxt();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 3'd0; m_data[0] = 32'h0000_00A0;
        push_req(0);
        @(negedge clk);
        nxt();
        @(negedge clk);
        nxt();
        m_addr[0] = 3'd1; m_data[0] = 32'h0000_00A1;
        push_req(0);
        @(negedge clk);
        nxt();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 3'd7; m_data[1] = '0;
        @(negedge clk);
        chk("ab_gap_cyc", wb_cyc, 0);
        chk("ab_gap_b", s_stall[1], 1);
        nxt();
        m_stb[1] = 1'b0; man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ab_drop_b1", s_ack[1], 0);
        chk("ab_drop_a1", s_ack[0], 0);
        chk("ab_b_owns", s_stall[1], 0);
        nxt();
        @(negedge clk);
        chk("ab_drop_b2", s_ack[1], 0);
        for (int i = 4; i < 7; i++) begin
            nxt();
            man_ack = 1'b0;
            m_stb[1] = 1'b1; m_addr[1] = 3'(i);
            push_req(1);
            @(negedge clk);
            chk("ab_b_accept", s_stall[1], 0);
        end
        nxt();
        m_stb[1] = 1'b0; man_ack = 1'b1; man_data = 32'h0B0B_0004; push_ack(1, man_data);
        @(negedge clk);
        nxt();
        man_data = 32'h0B0B_0005; push_ack(1, man_data);
        @(negedge clk);

        // Reset with one B request still outstanding
        nxt();
        man_ack = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_cyc", wb_cyc, 0);
        chk("mr_stb", wb_stb, 0);
        chk("mr_stall", s_stall, 2'b11);
        nxt();
        man_ack = 1'b1; man_data = 32'h0B0B_0006;
        @(negedge clk);
        chk("mr_no_ack_b", s_ack[1], 0);
        chk("mr_no_ack_a", s_ack[0], 0);
        nxt();
        man_ack = 1'b0; m_cyc[1] = 1'b0;
        @(negedge clk);

        // Fairness: both masters request continuously, 4 transactions per tenure
        nxt();
        auto_ack = 1'b1; m_we = '0; m_data = '0;
        m_cyc = 2'b11; m_stb = 2'b11; m_addr[0] = 3'd0; m_addr[1] = 3'd4;
        done = 1'b0;
        for (int x = 0; x < 2; x++) begin acc[x] = 0; ackc[x] = 0; wt[x] = 0; end
        for (int cy = 0; cy < 300 && !done; cy++) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                if (s_ack[x]) ackc[x]++;
                if (m_cyc[x] && m_stb[x] && !s_stall[x]) begin
                    if (acc[x] == 0) begin
                        glog.push_back(x);
                        chk("fair_wait", 64'(wt[x] <= 10), 1);
                    end
                    push_req(x);
                    push_ack(x, 32'hF00D_0000 | 32'(m_addr[x]));
                    acc[x]++;
                end else if (m_cyc[x] && acc[x] == 0) begin
                    wt[x]++;
                end
            end
            if (glog.size() == 6 && acc[glog[5]] == 4 && ackc[glog[5]] == 4) done = 1'b1;
            nxt();
            for (int x = 0; x < 2; x++) begin
                if (done) begin
                    m_cyc[x] = 1'b0; m_stb[x] = 1'b0;
                end else if (!m_cyc[x]) begin
                    m_cyc[x] = 1'b1; m_stb[x] = 1'b1; acc[x] = 0; ackc[x] = 0; wt[x] = 0;
                    m_addr[x] = 3'(x * 4);
                end else if (acc[x] == 4) begin
                    m_stb[x] = 1'b0;
                    if (ackc[x] == 4) m_cyc[x] = 1'b0;
                end else begin
                    m_addr[x] = 3'(x * 4 + acc[x]);
                end
            end
        end
        chk("fair_done", done, 1);
        chk("fair_grants", glog.size(), 6);
        foreach (glog[i]) chk("fair_order", glog[i], i % 2);
        repeat (3) nxt();
        auto_ack = 1'b0;
        nxt();

        chk("req_q_drained", req_q.size(), 0);
        chk("ack_qa_drained", ack_qa.size(), 0);
        chk("ack_qb_drained", ack_qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
